// File: rtl/arbitro_rr_param.sv
// NUM_CH-way class-to-destination FIFO arbiter: strict priority or round-robin grant,
// per-destination almost_full backpressure. Optional grant counters: ARBITRO_GRANT_CNT_EN.
module arbitro_rr_param #(
  parameter int          NUM_CH       = 4,
  parameter int          DATA_W       = 10,
  parameter int          DEST_LSB     = 8,
  parameter int          RR_MODE      = 1,
  parameter logic [3:0]  ACTIVE_STATE = 4'b1000,
  parameter int          CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 state,
  input  logic [NUM_CH-1:0]          in_empty,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          out_almost_full,
  input  logic [NUM_CH-1:0]          out_empty,
  output logic [NUM_CH-1:0]          pop,
  output logic [NUM_CH-1:0]          push,
  output logic [DATA_W-1:0]          out_data,
  output logic [2*NUM_CH-1:0]        empties,
  output logic                       idle
`ifdef ARBITRO_GRANT_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]    grant_cnt
`endif
);

  localparam int SEL_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || (NUM_CH & (NUM_CH - 1)) != 0 ||
      DATA_W < DEST_LSB + SEL_W || CNT_W < 1) begin : g_bad_param
    $error("arbitro_rr_param: unsupported parameter combination");
  end

  logic                  active;
  logic [NUM_CH-1:0]     elig;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]      ptr_base;
  logic [SEL_W-1:0]      scan_idx;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic [DATA_W-1:0]     grant_word;
  logic [SEL_W-1:0]      grant_dest;

  logic [NUM_CH-1:0]     push_q, push_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [2*NUM_CH-1:0]   empties_q, empties_d;
  logic                  idle_q, idle_d;

  assign active = (state == ACTIVE_STATE);

  // A channel is blocked only by its own destination, so other channels bypass it.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
    logic [SEL_W-1:0] dest;
    assign dest     = in_data[gi*DATA_W + DEST_LSB +: SEL_W];
    assign elig[gi] = active & ~in_empty[gi] & ~out_almost_full[dest];
  end

  // Strict priority is the round-robin scan with the start point pinned to channel 0.
  assign ptr_base = (RR_MODE != 0) ? rr_ptr_q : '0;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = SEL_W'(k) + ptr_base;
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (reset) begin
      grant_vld = 1'b0;
    end
  end

  assign grant_word = in_data[grant_idx*DATA_W +: DATA_W];
  assign grant_dest = grant_word[DEST_LSB +: SEL_W];

  always_comb begin
    pop = '0;
    if (grant_vld) begin
      pop[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    push_d     = '0;
    out_data_d = out_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_vld) begin
      push_d[grant_dest] = 1'b1;
      out_data_d         = grant_word;
      rr_ptr_d           = grant_idx + SEL_W'(1);
    end
    empties_d = {out_empty, in_empty};
    idle_d    = (&in_empty) & (&out_empty) & ~(|push_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q     <= '0;
      out_data_q <= '0;
      empties_q  <= '1;
      idle_q     <= 1'b1;
      rr_ptr_q   <= '0;
    end else begin
      push_q     <= push_d;
      out_data_q <= out_data_d;
      empties_q  <= empties_d;
      idle_q     <= idle_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign push     = push_q;
  assign out_data = out_data_q;
  assign empties  = empties_q;
  assign idle     = idle_q;

`ifdef ARBITRO_GRANT_CNT_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (!active) begin
        cnt_d = '0;
      end else if (pop[gi] && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
